ct_port_arb: RTL and testbench

CT_PORT_ARB -- requirements
Module: ct_port_arb

---
 rtl/ct_port_arb_if.sv | 38 +++
 rtl/ct_port_arb.sv | 142 ++++++++++++++
 tb/tb_ct_port_arb.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ct_port_arb_if.sv
// ---------------------------------------------------------------------------
// ct_port_arb_if
// Bundle of the requester-facing and memory-facing signals of ct_port_arb.
//
//   req        [N-1:0]   per-requester read request
//   lock       [N-1:0]   per-requester hold-ownership request
//   addr       [8*N-1:0] flattened request addresses, requester i at [8*i+7:8*i]
//   gnt        [N-1:0]   one-hot grant
//   rvalid     [N-1:0]   one-hot read-data-valid
//   rdata      [7:0]     read data broadcast to all requesters
//   mem_addr   [7:0]     address to the shared ct_mem read port
//   mem_rddata [7:0]     data returned by ct_mem
//
// slave  : the arbiter side.
// master : the environment side (requesters plus the memory model).
// ---------------------------------------------------------------------------
interface ct_port_arb_if #(
    parameter int N = 4
);
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [8*N-1:0] addr;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rvalid;
    logic [7:0]     rdata;
    logic [7:0]     mem_addr;
    logic [7:0]     mem_rddata;

    modport slave (
        input  req, lock, addr, mem_rddata,
        output gnt, rvalid, rdata, mem_addr
    );

    modport master (
        output req, lock, addr, mem_rddata,
        input  gnt, rvalid, rdata, mem_addr
    );
endinterface

// File: rtl/ct_port_arb.sv
// ---------------------------------------------------------------------------
// ct_port_arb
// Round-robin arbiter sharing one ct_mem read port between N crack engines,
// with an optional lock that lets the current owner keep the port, and a
// grant-tag pipeline that routes returning data back to the right requester.
//
//   clk    : clock, all state updates on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : ct_port_arb_if.slave (req/lock/addr in, gnt/rvalid/rdata out,
//            mem_addr out, mem_rddata in)
//
// Parameters: N requesters (2..8), LAT memory read latency in cycles (1..3).
// ---------------------------------------------------------------------------
module ct_port_arb #(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    ct_port_arb_if.slave   bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  owner_q, owner_d;

    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic           hold_lock;
    logic           grant_valid;
    logic [IW-1:0]  grant_idx;

    logic [LAT-1:0] tag_valid_q;
    logic [IW-1:0]  tag_idx_q [LAT];

    // Round-robin pick: scanning from the highest offset down means the
    // last hit written is the lowest offset from rr_ptr, i.e. the first
    // requester found scanning upward with wrap.
    always_comb begin
        logic [IW-1:0] cand;
        cand       = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_ptr_q) + k) % N);
            if (bus.req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // The owner keeps the port only while its lock stays high; the cycle it
    // drops lock is arbitrated normally.
    assign hold_lock = (state_q == LOCKED) && bus.lock[owner_q];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        if (!hold_lock) begin
            state_d = ARB;
            if (grant_valid) begin
                rr_ptr_d = (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
                if (bus.lock[grant_idx]) begin
                    state_d = LOCKED;
                    owner_d = grant_idx;
                end
            end
        end
    end

    // Output logic: grant and memory address. Gated by rst_n so the port is
    // quiet for the whole reset period, not just after the first edge.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = owner_q;
        if (hold_lock) begin
            grant_valid = bus.req[owner_q];
        end else begin
            grant_valid = pick_valid;
            grant_idx   = pick_idx;
        end
        if (!rst_n) begin
            grant_valid = 1'b0;
        end
        bus.gnt = '0;
        if (grant_valid) begin
            bus.gnt[grant_idx] = 1'b1;
        end
        bus.mem_addr = grant_valid ? bus.addr[int'(grant_idx) * 8 +: 8] : 8'h00;
    end

    // Grant-tag pipeline: stage LAT-1 lines up with mem_rddata for the
    // access granted LAT cycles earlier. Reset wipes in-flight tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < LAT; s++) begin
                tag_valid_q[s] <= 1'b0;
                tag_idx_q[s]   <= '0;
            end
        end else begin
            tag_valid_q[0] <= grant_valid;
            tag_idx_q[0]   <= grant_idx;
            for (int s = 1; s < LAT; s++) begin
                tag_valid_q[s] <= tag_valid_q[s-1];
                tag_idx_q[s]   <= tag_idx_q[s-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rvalid
            assign bus.rvalid[gi] = tag_valid_q[LAT-1] && (tag_idx_q[LAT-1] == IW'(gi));
        end
    endgenerate

    // Forced to zero when idle so rdata is never X, even if memory is.
    assign bus.rdata = tag_valid_q[LAT-1] ? bus.mem_rddata : 8'h00;

endmodule

// File: tb/tb_ct_port_arb.sv
// ---------------------------------------------------------------------------
// tb_ct_port_arb
// Self-checking bench for ct_port_arb. Two instances share clock and reset:
// dut1 (LAT=1) runs a table of per-cycle vectors, dut3 (LAT=3) runs a short
// hand-written sequence. Read returns are checked through per-DUT scoreboard
// queues filled when a grant is expected.
// ---------------------------------------------------------------------------
module tb_ct_port_arb;
    localparam int N = 4;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic [3:0] exp_gnt;
        string      name;
    } vec_t;

    typedef struct {
        int         due;
        logic [3:0] rv;
        logic [7:0] rd;
    } sb_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    sb_t        q1[$];
    sb_t        q3[$];
    logic [7:0] a1 [4];
    logic [7:0] a3 [4];
    vec_t       tbl [23];

    always #5 clk = ~clk;

    ct_port_arb_if #(.N(N)) bus1 ();
    ct_port_arb_if #(.N(N)) bus3 ();

    ct_port_arb #(.N(N), .LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    ct_port_arb #(.N(N), .LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

    function automatic logic [7:0] rom(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    // Memory models: data valid LAT cycles after the address is presented.
    logic [7:0] m1_q;
    logic [7:0] m3_q [3];
    always @(posedge clk) begin
        m1_q    <= rom(bus1.mem_addr);
        m3_q[0] <= rom(bus3.mem_addr);
        m3_q[1] <= m3_q[0];
        m3_q[2] <= m3_q[1];
    end
    assign bus1.mem_rddata = m1_q;
    assign bus3.mem_rddata = m3_q[2];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_rv();
        sb_t e;
        logic hit;
        hit = 1'b0;
        if (q1.size() > 0) begin
            if (q1[0].due == cyc) hit = 1'b1;
        end
        if (hit) begin
            e = q1.pop_front();
            check("rvalid1", 8'(bus1.rvalid), 8'(e.rv));
            check("rdata1", bus1.rdata, e.rd);
        end else begin
            check("rvalid1_idle", 8'(bus1.rvalid), 8'h00);
        end
        hit = 1'b0;
        if (q3.size() > 0) begin
            if (q3[0].due == cyc) hit = 1'b1;
        end
        if (hit) begin
            e = q3.pop_front();
            check("rvalid3", 8'(bus3.rvalid), 8'(e.rv));
            check("rdata3", bus3.rdata, e.rd);
        end else begin
            check("rvalid3_idle", 8'(bus3.rvalid), 8'h00);
        end
    endtask

    task automatic step(input int which, input logic [3:0] req, input logic [3:0] lock,
                        input logic [3:0] exp_gnt, input string name);
        logic [7:0] exp_ma;
        sb_t        e;
        exp_ma = 8'h00;
        if (which == 1) begin
            bus1.req = req;  bus1.lock = lock;
            bus3.req = '0;   bus3.lock = '0;
        end else begin
            bus3.req = req;  bus3.lock = lock;
            bus1.req = '0;   bus1.lock = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) exp_ma = (which == 1) ? a1[i] : a3[i];
        end
        @(negedge clk);
        check_rv();
        if (which == 1) begin
            check({name, "_gnt"}, 8'(bus1.gnt), 8'(exp_gnt));
            check({name, "_maddr"}, bus1.mem_addr, exp_ma);
            check({name, "_gnt3_idle"}, 8'(bus3.gnt), 8'h00);
        end else begin
            check({name, "_gnt"}, 8'(bus3.gnt), 8'(exp_gnt));
            check({name, "_maddr"}, bus3.mem_addr, exp_ma);
            check({name, "_gnt1_idle"}, 8'(bus1.gnt), 8'h00);
        end
        $display("cyc %0d %s dut%0d req=%b lock=%b gnt1=%b gnt3=%b rv1=%b rv3=%b",
                 cyc, name, which, req, lock, bus1.gnt, bus3.gnt, bus1.rvalid, bus3.rvalid);
        if (exp_gnt != 4'b0000) begin
            e.due = cyc + ((which == 1) ? 1 : 3);
            e.rv  = exp_gnt;
            e.rd  = rom(exp_ma);
            if (which == 1) q1.push_back(e);
            else            q3.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_gnt1"},   8'(bus1.gnt),    8'h00);
        check({name, "_rv1"},    8'(bus1.rvalid), 8'h00);
        check({name, "_maddr1"}, bus1.mem_addr,   8'h00);
        check({name, "_rdata1"}, bus1.rdata,      8'h00);
        check({name, "_gnt3"},   8'(bus3.gnt),    8'h00);
        check({name, "_rv3"},    8'(bus3.rvalid), 8'h00);
        check({name, "_maddr3"}, bus3.mem_addr,   8'h00);
        check({name, "_rdata3"}, bus3.rdata,      8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        a1[0] = 8'h00; a1[1] = 8'h10; a1[2] = 8'h20; a1[3] = 8'h30;
        a3[0] = 8'h22; a3[1] = 8'h11; a3[2] = 8'h05; a3[3] = 8'h33;

        tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, "rr_a"};
        tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, "rr_b"};
        tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, "rr_c"};
        tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, "rr_d"};
        tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, "rr_wrap"};
        tbl[5]  = '{4'b0000, 4'b0000, 4'b0000, "idle"};
        tbl[6]  = '{4'b1000, 4'b0000, 4'b1000, "ptr_to0"};
        tbl[7]  = '{4'b0100, 4'b0000, 4'b0100, "single2"};
        tbl[8]  = '{4'b1001, 4'b0000, 4'b1000, "scan3"};
        tbl[9]  = '{4'b1001, 4'b0000, 4'b0001, "scan0"};
        tbl[10] = '{4'b1111, 4'b0010, 4'b0010, "lock1_take"};
        tbl[11] = '{4'b1111, 4'b0010, 4'b0010, "lock1_hold"};
        tbl[12] = '{4'b1111, 4'b0010, 4'b0010, "lock1_hold"};
        tbl[13] = '{4'b1111, 4'b0010, 4'b0010, "lock1_hold"};
        tbl[14] = '{4'b1111, 4'b0010, 4'b0010, "lock1_hold"};
        tbl[15] = '{4'b1111, 4'b0000, 4'b0100, "lock1_release"};
        tbl[16] = '{4'b1111, 4'b1000, 4'b1000, "lock3_take"};
        tbl[17] = '{4'b0111, 4'b1000, 4'b0000, "lock3_noreq"};
        tbl[18] = '{4'b0111, 4'b1000, 4'b0000, "lock3_noreq"};
        tbl[19] = '{4'b0111, 4'b1000, 4'b0000, "lock3_noreq"};
        tbl[20] = '{4'b1111, 4'b1000, 4'b1000, "lock3_resume"};
        tbl[21] = '{4'b1111, 4'b0000, 4'b0001, "lock3_release"};
        tbl[22] = '{4'b0000, 4'b0000, 4'b0000, "idle"};

        bus1.addr = {a1[3], a1[2], a1[1], a1[0]};
        bus3.addr = {a3[3], a3[2], a3[1], a3[0]};
        bus1.req  = 4'b1111; bus1.lock = 4'b0000;
        bus3.req  = 4'b1111; bus3.lock = 4'b0000;

        // Outputs must be quiet while reset is held, even with requests up.
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;

        for (int i = 0; i < 23; i++) begin
            step(1, tbl[i].req, tbl[i].lock, tbl[i].exp_gnt, tbl[i].name);
        end

        // Reset pulse while a read is in flight: the tag must be dropped and
        // the pointer must restart at 0.
        step(1, 4'b0100, 4'b0000, 4'b0100, "pre_rst");
        rst_n    = 1'b0;
        bus1.req = 4'b1111;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        q1.delete();
        q3.delete();
        $display("cyc %0d mid_rst gnt1=%b rv1=%b", cyc, bus1.gnt, bus1.rvalid);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
        step(1, 4'b1111, 4'b0000, 4'b0001, "post_rst");
        step(1, 4'b0000, 4'b0000, 4'b0000, "idle");

        // LAT=3 instance: single access, then back-to-back grants.
        step(3, 4'b0100, 4'b0000, 4'b0100, "l3_single");
        step(3, 4'b0000, 4'b0000, 4'b0000, "l3_wait");
        step(3, 4'b0000, 4'b0000, 4'b0000, "l3_wait");
        step(3, 4'b0000, 4'b0000, 4'b0000, "l3_data");
        step(3, 4'b0011, 4'b0000, 4'b0001, "l3_b2b_a");
        step(3, 4'b0011, 4'b0000, 4'b0010, "l3_b2b_b");
        for (int i = 0; i < 4; i++) begin
            step(3, 4'b0000, 4'b0000, 4'b0000, "l3_drain");
        end

        check("sb1_drained", 8'(q1.size()), 8'h00);
        check("sb3_drained", 8'(q3.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
